// File: rtl/i2c_ext_pkg.sv
// Shared constants and bus-event classification for the I2C bus extender.
package i2c_ext_pkg;
  localparam int   NUM_SEG         = 8;
  localparam int   SEL_W           = 3;
  localparam int   SYNC_STAGES_DEF = 2;
  localparam int   FILT_LEN_DEF    = 3;
  localparam logic LINE_IDLE       = 1'b1;

  typedef enum logic [1:0] {
    EV_NONE,
    EV_START,
    EV_STOP
  } bus_ev_e;

  // SCL must be high on both samples; an SCL edge alongside the SDA edge is no event.
  function automatic bus_ev_e classify(input logic scl_prev, input logic scl_now,
                                       input logic sda_prev, input logic sda_now);
    if (!(scl_prev && scl_now) || (sda_prev == sda_now)) return EV_NONE;
    return sda_now ? EV_STOP : EV_START;
  endfunction
endpackage

// File: rtl/i2c_line_cond.sv
// Input conditioning for one I2C line: synchroniser plus, when
// I2C_GLITCH_FILTER_EN is defined, a consecutive-sample glitch filter.
module i2c_line_cond
  import i2c_ext_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic line_i,
  output logic line_o
);
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   samp;
  logic                   filt_q;
  logic                   filt_d;

  if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || FILT_LEN < 2 || FILT_LEN > 8) begin : g_bad_param
    $error("i2c_line_cond: SYNC_STAGES or FILT_LEN out of range");
  end

  assign samp   = sync_q[SYNC_STAGES-1];
  assign line_o = filt_q;

`ifdef I2C_GLITCH_FILTER_EN
  localparam int CNT_W = $clog2(FILT_LEN) + 1;

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // NOTE: every output of a combinational block gets a default first, otherwise a latch is inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '0;
    if (samp != filt_q) begin
      if (cnt_q == CNT_W'(FILT_LEN - 1)) filt_d = samp;
      else                               cnt_d  = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
      filt_q <= LINE_IDLE;
      cnt_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      filt_q <= filt_d;
      cnt_q  <= cnt_d;
    end
  end
`else
  assign filt_d = samp;

  // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q <= {SYNC_STAGES{LINE_IDLE}};
      filt_q <= LINE_IDLE;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], line_i};
      filt_q <= filt_d;
    end
  end
`endif
endmodule

// File: rtl/i2c_bus_extender.sv
// Fans one I2C master out to eight segments; SDA routed by a select latched only
// while the bus is idle. Optional glitch filter: I2C_GLITCH_FILTER_EN.
module i2c_bus_extender
  import i2c_ext_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int FILT_LEN    = FILT_LEN_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scl_in,
  input  logic             sda_in,
  input  logic [SEL_W-1:0] sel,
  output logic             scl_out,
  output logic             sda_out1,
  output logic             sda_out2,
  output logic             sda_out3,
  output logic             sda_out4,
  output logic             sda_out5,
  output logic             sda_out6,
  output logic             sda_out7,
  output logic             sda_out8
);
  logic               scl_f;
  logic               sda_f;
  logic               scl_prev_q;
  logic               sda_prev_q;
  logic               busy_q;
  logic               busy_d;
  logic [SEL_W-1:0]   sel_q;
  logic [SEL_W-1:0]   sel_d;
  logic [NUM_SEG-1:0] seg_sda;
  bus_ev_e            ev;

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_scl_cond (
    .clk    (clk),
    .rst    (rst),
    .line_i (scl_in),
    .line_o (scl_f)
  );

  i2c_line_cond #(.SYNC_STAGES(SYNC_STAGES), .FILT_LEN(FILT_LEN)) u_sda_cond (
    .clk    (clk),
    .rst    (rst),
    .line_i (sda_in),
    .line_o (sda_f)
  );

  assign ev = classify(scl_prev_q, scl_f, sda_prev_q, sda_f);

  // The select only moves while idle and never on the cycle a START appears.
  always_comb begin
    busy_d = busy_q;
    sel_d  = sel_q;
    case (ev)
      EV_START: busy_d = 1'b1;
      EV_STOP:  busy_d = 1'b0;
      default:  ;
    endcase
    if (!busy_q && ev != EV_START) sel_d = sel;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      scl_prev_q <= LINE_IDLE;
      sda_prev_q <= LINE_IDLE;
      busy_q     <= 1'b0;
      sel_q      <= '0;
    end else begin
      scl_prev_q <= scl_f;
      sda_prev_q <= sda_f;
      busy_q     <= busy_d;
      sel_q      <= sel_d;
    end
  end

  always_comb begin
    seg_sda        = {NUM_SEG{LINE_IDLE}};
    seg_sda[sel_q] = sda_f;
  end

  assign scl_out  = scl_f;
  assign sda_out1 = seg_sda[0];
  assign sda_out2 = seg_sda[1];
  assign sda_out3 = seg_sda[2];
  assign sda_out4 = seg_sda[3];
  assign sda_out5 = seg_sda[4];
  assign sda_out6 = seg_sda[5];
  assign sda_out7 = seg_sda[6];
  assign sda_out8 = seg_sda[7];
endmodule

// File: tb/tb_i2c_bus_extender.sv
// Self-checking bench for i2c_bus_extender: directed tables, corner sequences and
// randomized traffic against a history-based reference model.
module tb_i2c_bus_extender;
  localparam int S = 2;
  localparam int F = 3;
`ifdef I2C_GLITCH_FILTER_EN
  localparam int FEFF = F;
`else
  localparam int FEFF = 1;
`endif
  localparam int LAT = S + FEFF;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       scl_in = 1'b1;
  logic       sda_in = 1'b1;
  logic [2:0] sel = 3'd0;
  logic       scl_out;
  logic       sda_out1, sda_out2, sda_out3, sda_out4;
  logic       sda_out5, sda_out6, sda_out7, sda_out8;
  logic [7:0] segs;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  i2c_bus_extender #(.SYNC_STAGES(S), .FILT_LEN(F)) dut (
    .clk      (clk),
    .rst      (rst),
    .scl_in   (scl_in),
    .sda_in   (sda_in),
    .sel      (sel),
    .scl_out  (scl_out),
    .sda_out1 (sda_out1),
    .sda_out2 (sda_out2),
    .sda_out3 (sda_out3),
    .sda_out4 (sda_out4),
    .sda_out5 (sda_out5),
    .sda_out6 (sda_out6),
    .sda_out7 (sda_out7),
    .sda_out8 (sda_out8)
  );

  assign segs = {sda_out8, sda_out7, sda_out6, sda_out5, sda_out4, sda_out3, sda_out2, sda_out1};

  // Reference model: a filtered line takes a new value once the last FEFF input
  // samples, taken S edges back, all disagree with it.
  logic [15:0] h_scl, h_sda, nh_scl, nh_sda;
  logic        m_scl, m_sda, m_pscl, m_psda, m_busy, m_start, m_stop;
  logic [2:0]  m_sel;

  function automatic logic flips(input logic [15:0] h, input logic cur);
    for (int i = S; i < S + FEFF; i++) if (h[i] == cur) return 1'b0;
    return 1'b1;
  endfunction

  always_comb begin
    nh_scl  = {h_scl[14:0], scl_in};
    nh_sda  = {h_sda[14:0], sda_in};
    m_start = m_pscl && m_scl && m_psda && !m_sda;
    m_stop  = m_pscl && m_scl && !m_psda && m_sda;
  end

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      h_scl  <= '1;
      h_sda  <= '1;
      m_scl  <= 1'b1;
      m_sda  <= 1'b1;
      m_pscl <= 1'b1;
      m_psda <= 1'b1;
      m_busy <= 1'b0;
      m_sel  <= 3'd0;
    end else begin
      h_scl  <= nh_scl;
      h_sda  <= nh_sda;
      m_scl  <= flips(nh_scl, m_scl) ? ~m_scl : m_scl;
      m_sda  <= flips(nh_sda, m_sda) ? ~m_sda : m_sda;
      m_pscl <= m_scl;
      m_psda <= m_sda;
      m_busy <= m_start ? 1'b1 : (m_stop ? 1'b0 : m_busy);
      if (!m_busy && !m_start) m_sel <= sel;
    end
  end

  function automatic logic [7:0] seg_vec(input logic [2:0] s, input logic d);
    logic [7:0] v;
    v    = 8'hFF;
    v[s] = d;
    return v;
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Low pulse on SDA of plen clocks; the selected segment shows it LAT edges later.
  task automatic sda_pulse_check(input string nm, input int plen, input logic [7:0] low_vec);
    sda_in = 1'b0;
    for (int j = 1; j <= LAT + plen + 3; j++) begin
      @(negedge clk);
      check(nm, {24'd0, segs}, {24'd0, (j >= LAT && j < LAT + plen) ? low_vec : 8'hFF});
      if (j == plen) sda_in = 1'b1;
    end
  endtask

  task automatic scl_pulse_check(input string nm, input int plen, input logic passes);
    scl_in = 1'b0;
    for (int j = 1; j <= LAT + plen + 4; j++) begin
      @(negedge clk);
      check(nm, {31'd0, scl_out}, {31'd0, !(passes && j >= LAT && j < LAT + plen)});
      if (j == plen) scl_in = 1'b1;
    end
  endtask

  typedef struct {
    logic [2:0] sel;
    int         plen;
    logic [7:0] low_vec;
  } route_vec_t;

  route_vec_t rt[4];
  logic       old_scl;
  logic [7:0] data_byte;
  int         r;
  int         hold;

  initial begin
    rt[0] = '{sel: 3'd3, plen: 4, low_vec: 8'hF7};
    rt[1] = '{sel: 3'd0, plen: 5, low_vec: 8'hFE};
    rt[2] = '{sel: 3'd7, plen: 3, low_vec: 8'h7F};
    rt[3] = '{sel: 3'd5, plen: 6, low_vec: 8'hDF};

    // Reset with inputs low and a nonzero select.
    scl_in = 1'b0;
    sda_in = 1'b0;
    sel    = 3'd5;
    #1 rst = 1'b1;
    #1 check("reset outputs", {23'd0, scl_out, segs}, {23'd0, 9'h1FF});
    @(negedge clk);
    tick(2);
    check("reset held", {23'd0, scl_out, segs}, {23'd0, 9'h1FF});
    sel = 3'd0;
    rst = 1'b0;
    tick(LAT - 1);
    check("release before latency", {23'd0, scl_out, segs}, {23'd0, 9'h1FF});
    tick(1);
    check("release at latency", {23'd0, scl_out, segs}, {23'd0, 1'b0, 8'hFE});
    tick(10 - LAT);
    for (int k = 0; k < 4; k++) begin
      old_scl = scl_in;
      scl_in  = ~scl_in;
      tick(LAT - 1);
      check("scl hold", {31'd0, scl_out}, {31'd0, old_scl});
      tick(1);
      check("scl follow", {31'd0, scl_out}, {31'd0, ~old_scl});
      tick(10 - LAT);
    end
    // Not busy, so a new select is accepted and carries the low SDA.
    sel = 3'd4;
    tick(3);
    check("not busy after release", {24'd0, segs}, {24'd0, 8'hEF});
    scl_in = 1'b1;
    tick(8);
    sda_in = 1'b1;
    tick(8);

    // Routing table.
    for (int t = 0; t < 4; t++) begin
      sel = rt[t].sel;
      tick(4);
      sda_pulse_check("route", rt[t].plen, rt[t].low_vec);
      tick(4);
    end

    // Glitch handling on SCL.
`ifdef I2C_GLITCH_FILTER_EN
    scl_pulse_check("scl short pulse suppressed", F - 1, 1'b0);
    tick(4);
    scl_pulse_check("scl min pulse passes", F, 1'b1);
`else
    scl_pulse_check("scl 1clk pulse passes", 1, 1'b1);
    tick(4);
    scl_pulse_check("scl 2clk pulse passes", 2, 1'b1);
`endif
    tick(4);

    // Select locked during a transaction.
    sel = 3'd2;
    tick(4);
    sda_in = 1'b0;
    tick(LAT + 2);
    check("lock start seg3", {24'd0, segs}, {24'd0, 8'hFB});
    scl_in = 1'b0;
    tick(5);
    sel       = 3'd6;
    data_byte = 8'hA5;
    for (int b = 7; b >= 0; b--) begin
      sda_in = data_byte[b];
      tick(4);
      scl_in = 1'b1;
      tick(LAT + 1);
      check("lock data seg3", {24'd0, segs}, {24'd0, seg_vec(3'd2, data_byte[b])});
      scl_in = 1'b0;
      tick(4);
    end
    sda_in = 1'b0;
    tick(4);
    scl_in = 1'b1;
    tick(LAT + 2);
    check("lock before stop", {24'd0, segs}, {24'd0, 8'hFB});
    sda_in = 1'b1;
    tick(LAT + 3);
    check("lock after stop idle", {24'd0, segs}, {24'd0, 8'hFF});
    tick(2);
    sda_in = 1'b0;
    tick(LAT + 1);
    check("new sel after stop", {24'd0, segs}, {24'd0, 8'hBF});
    sda_in = 1'b1;
    tick(LAT + 4);

    // Reset in the middle of a transaction.
    sel = 3'd7;
    tick(4);
    sda_in = 1'b0;
    tick(LAT + 2);
    check("pre-reset seg8 low", {24'd0, segs}, {24'd0, 8'h7F});
    #2 rst = 1'b1;
    #1 check("async reset outputs", {23'd0, scl_out, segs}, {23'd0, 9'h1FF});
    sda_in = 1'b1;
    sel    = 3'd1;
    @(negedge clk);
    rst = 1'b0;
    tick(4);
    sda_pulse_check("post-reset seg2", 4, 8'hFD);
    tick(4);

    // Repeated START keeps the bus busy and the routing fixed.
    sel = 3'd4;
    tick(4);
    sda_in = 1'b0;
    tick(LAT + 2);
    check("first start seg5", {24'd0, segs}, {24'd0, 8'hEF});
    scl_in = 1'b0;
    tick(5);
    sel = 3'd1;
    tick(1);
    sda_in = 1'b1;
    tick(5);
    scl_in = 1'b1;
    tick(LAT + 2);
    check("between starts", {24'd0, segs}, {24'd0, 8'hFF});
    sda_in = 1'b0;
    tick(LAT + 2);
    check("repeated start seg5", {24'd0, segs}, {24'd0, 8'hEF});
    sda_in = 1'b1;
    tick(LAT + 3);
    tick(3);
    sda_pulse_check("after stop seg2", 4, 8'hFD);
    tick(4);

    // Randomized traffic against the reference model.
    for (int k = 0; k < 300; k++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      scl_in = ~scl_in;
      else if (r <= 7) sda_in = ~sda_in;
      else if (r == 8) begin
        scl_in = ~scl_in;
        sda_in = ~sda_in;
      end else sel = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 4) == 0) sel = 3'($urandom_range(0, 7));
      hold = $urandom_range(1, 6);
      repeat (hold) begin
        @(negedge clk);
        check("random vs model", {23'd0, scl_out, segs}, {23'd0, m_scl, seg_vec(m_sel, m_sda)});
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
